mam_req_arbiter: RTL and testbench



---
 rtl/mam_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mam_req_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mam_req_arbiter.sv
// Round-robin arbiter sharing one MAM request/write/read interface between PORTS requesters.
// A grant covers the request handshake plus every data beat of that transaction.
module mam_req_arbiter #(
  parameter  int unsigned PORTS      = 2,
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned ADDR_WIDTH = 32,
  localparam int unsigned GW         = (PORTS > 2) ? $clog2(PORTS) : 1,
  localparam int unsigned SW         = DATA_WIDTH / 8,
  localparam int unsigned BW         = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            in_req_valid,
  output logic [PORTS-1:0]            in_req_ready,
  input  logic [PORTS-1:0]            in_req_rw,
  input  logic [PORTS*ADDR_WIDTH-1:0] in_req_addr,
  input  logic [PORTS-1:0]            in_req_burst,
  input  logic [PORTS*BW-1:0]         in_req_beats,
  input  logic [PORTS-1:0]            in_write_valid,
  input  logic [PORTS*DATA_WIDTH-1:0] in_write_data,
  input  logic [PORTS*SW-1:0]         in_write_strb,
  output logic [PORTS-1:0]            in_write_ready,
  output logic [PORTS-1:0]            in_read_valid,
  output logic [DATA_WIDTH-1:0]       in_read_data,
  input  logic [PORTS-1:0]            in_read_ready,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic                        req_rw,
  output logic [ADDR_WIDTH-1:0]       req_addr,
  output logic                        req_burst,
  output logic [BW-1:0]               req_beats,
  output logic                        write_valid,
  output logic [DATA_WIDTH-1:0]       write_data,
  output logic [SW-1:0]               write_strb,
  input  logic                        write_ready,
  input  logic                        read_valid,
  input  logic [DATA_WIDTH-1:0]       read_data,
  output logic                        read_ready,
  output logic [GW-1:0]               grant
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, READ} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grant, w_grant_nxt;
  logic [GW-1:0]   r_ptr, w_ptr_nxt;
  logic [BW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_any;
  logic [GW-1:0]   w_win;
  logic [GW-1:0]   w_ptr_wrap;
  int unsigned     w_idx;

  logic [ADDR_WIDTH-1:0] w_addr  [PORTS];
  logic [BW-1:0]         w_beats [PORTS];
  logic [DATA_WIDTH-1:0] w_wdata [PORTS];
  logic [SW-1:0]         w_wstrb [PORTS];

  // Split the flattened per-port buses into indexable arrays.
  for (genvar gi = 0; gi < int'(PORTS); gi++) begin : g_port
    assign w_addr[gi]  = in_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_beats[gi] = in_req_beats[gi*BW +: BW];
    assign w_wdata[gi] = in_write_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_wstrb[gi] = in_write_strb[gi*SW +: SW];
  end

  assign grant      = r_grant;
  assign w_ptr_wrap = (32'(r_grant) == PORTS - 1) ? '0 : r_grant + GW'(1);

  // First requesting port at or above the pointer, wrapping around.
  always_comb begin : p_pick
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = 0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      w_idx = (32'(r_ptr) + i) % PORTS;
      if (!w_any && in_req_valid[GW'(w_idx)]) begin
        w_any = 1'b1;
        w_win = GW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Channel muxing is gated by state so idle/reset leaves every output at zero.
  always_comb begin : p_fsm
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    in_req_ready   = '0;
    in_write_ready = '0;
    in_read_valid  = '0;
    in_read_data   = '0;
    req_valid      = 1'b0;
    req_rw         = 1'b0;
    req_addr       = '0;
    req_burst      = 1'b0;
    req_beats      = '0;
    write_valid    = 1'b0;
    write_data     = '0;
    write_strb     = '0;
    read_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_win;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        req_valid             = in_req_valid[r_grant];
        req_rw                = in_req_rw[r_grant];
        req_addr              = w_addr[r_grant];
        req_burst             = in_req_burst[r_grant];
        req_beats             = w_beats[r_grant];
        in_req_ready[r_grant] = req_ready;
        if (!in_req_valid[r_grant]) begin
          w_state_nxt = IDLE;
        end else if (req_ready) begin
          w_cnt_nxt   = (in_req_burst[r_grant] && w_beats[r_grant] != '0) ? w_beats[r_grant] : BW'(1);
          w_state_nxt = in_req_rw[r_grant] ? WRITE : READ;
        end
      end
      WRITE: begin
        write_valid             = in_write_valid[r_grant];
        write_data              = w_wdata[r_grant];
        write_strb              = w_wstrb[r_grant];
        in_write_ready[r_grant] = write_ready;
        if (in_write_valid[r_grant] && write_ready) begin
          w_cnt_nxt = r_cnt - BW'(1);
          if (r_cnt == BW'(1)) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = w_ptr_wrap;
          end
        end
      end
      READ: begin
        read_ready             = in_read_ready[r_grant];
        in_read_valid[r_grant] = read_valid;
        in_read_data           = read_data;
        if (read_valid && in_read_ready[r_grant]) begin
          w_cnt_nxt = r_cnt - BW'(1);
          if (r_cnt == BW'(1)) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = w_ptr_wrap;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mam_req_arbiter.sv
// Bench for mam_req_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_mam_req_arbiter;
  localparam int unsigned P  = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned GW = 2;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic          burst;
    logic [13:0]   beats;
    logic [DW-1:0] base;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [P-1:0]    in_req_valid, in_req_ready, in_req_rw, in_req_burst;
  logic [P*AW-1:0] in_req_addr;
  logic [P*14-1:0] in_req_beats;
  logic [P-1:0]    in_write_valid, in_write_ready, in_read_valid, in_read_ready;
  logic [P*DW-1:0] in_write_data;
  logic [P*SW-1:0] in_write_strb;
  logic [DW-1:0]   in_read_data;
  logic            req_valid, req_ready, req_rw, req_burst;
  logic [AW-1:0]   req_addr;
  logic [13:0]     req_beats;
  logic            write_valid, write_ready;
  logic [DW-1:0]   write_data;
  logic [SW-1:0]   write_strb;
  logic            read_valid, read_ready;
  logic [DW-1:0]   read_data;
  logic [GW-1:0]   grant;

  mam_req_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
    .in_req_addr(in_req_addr), .in_req_burst(in_req_burst), .in_req_beats(in_req_beats),
    .in_write_valid(in_write_valid), .in_write_data(in_write_data), .in_write_strb(in_write_strb),
    .in_write_ready(in_write_ready), .in_read_valid(in_read_valid), .in_read_data(in_read_data),
    .in_read_ready(in_read_ready), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats), .write_valid(write_valid),
    .write_data(write_data), .write_strb(write_strb), .write_ready(write_ready),
    .read_valid(read_valid), .read_data(read_data), .read_ready(read_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  txn_t        q [P][$];
  txn_t        cur;
  int unsigned stage;
  int unsigned e_port, e_ptr, dbeat, dtot, cyc, bp_mode, n_wr_hs, n_rd_hs;
  logic        rv_hold;
  logic [DW-1:0] rd_base;
  bit          gen_on;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned eff(input txn_t t);
    return (t.burst && t.beats != 0) ? 32'(t.beats) : 1;
  endfunction

  function automatic int unsigned winner(input int unsigned ptr, input logic [P-1:0] v);
    for (int unsigned i = 0; i < P; i++) if (v[(ptr + i) % P]) return (ptr + i) % P;
    return ptr;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.rw = 1'($urandom); t.addr = $urandom; t.burst = 1'($urandom);
    t.beats = 14'($urandom_range(0, 12)); t.base = DW'($urandom);
    return t;
  endfunction

  function automatic bit all_empty();
    for (int p = 0; p < P; p++) if (q[p].size() != 0) return 0;
    return 1;
  endfunction

  task automatic push(input int p, input logic rw, input logic [AW-1:0] a, input logic b,
                      input logic [13:0] n, input logic [DW-1:0] base);
    txn_t t;
    t.rw = rw; t.addr = a; t.burst = b; t.beats = n; t.base = base;
    q[p].push_back(t);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valids"}, 64'({req_valid, write_valid, read_ready, in_req_ready, in_write_ready, in_read_valid}), 64'(0));
    chk({tag, "_req"}, 64'({req_rw, req_burst, req_beats, req_addr}), 64'(0));
    chk({tag, "_data"}, 64'({write_data, write_strb, in_read_data}), 64'(0));
    chk({tag, "_grant"}, 64'(grant), 64'(0));
  endtask

  // One clock: drive at negedge, check after settling, advance the model at posedge.
  task automatic step();
    txn_t h;
    logic rdy;
    bit   act;
    @(negedge clk);
    cyc++;
    if (gen_on) for (int p = 0; p < P; p++) if (q[p].size() < 2 && $urandom_range(0, 5) == 0) q[p].push_back(rand_txn());
    rdy = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? cyc[0] : 1'($urandom);
    for (int p = 0; p < P; p++) begin
      act = (stage >= 2) && (e_port == 32'(p));
      h = (q[p].size() > 0) ? q[p][0] : rand_txn();
      in_req_valid[p] = (q[p].size() > 0) && !act;
      in_req_rw[p] = h.rw; in_req_burst[p] = h.burst;
      in_req_addr[p*AW +: AW] = h.addr; in_req_beats[p*14 +: 14] = h.beats;
      in_write_valid[p] = act && stage == 2;
      in_write_data[p*DW +: DW] = in_write_valid[p] ? DW'(cur.base + DW'(dbeat)) : DW'($urandom);
      in_write_strb[p*SW +: SW] = in_write_valid[p] ? (SW'(cur.base) ^ SW'(dbeat)) : SW'($urandom);
      in_read_ready[p] = (act && stage == 3) ? rdy : 1'($urandom);
    end
    req_ready = (bp_mode == 2) ? 1'($urandom) : 1'b1;
    write_ready = rdy;
    read_valid = (stage == 3) && (rv_hold || bp_mode != 2 || $urandom_range(0, 1) == 1);
    read_data = read_valid ? DW'(rd_base + DW'(dbeat) + DW'(1)) : DW'($urandom);
    #1;
    if (!rst) begin
      case (stage)
        0: chk("idle_outputs", 64'({req_valid, write_valid, read_ready, in_req_ready, in_write_ready, in_read_valid}), 64'(0));
        1: begin
          h = q[e_port][0];
          chk("req_grant", 64'(grant), 64'(e_port));
          chk("req_valid", 64'(req_valid), 64'(1));
          chk("req_fields", 64'({req_rw, req_burst, req_beats}), 64'({h.rw, h.burst, h.beats}));
          chk("req_addr", 64'(req_addr), 64'(h.addr));
          chk("in_req_ready", 64'(in_req_ready), 64'(P'(req_ready) << e_port));
          chk("req_quiet", 64'({write_valid, read_ready, in_write_ready, in_read_valid}), 64'(0));
        end
        2: begin
          chk("wr_grant", 64'(grant), 64'(e_port));
          chk("wr_valid", 64'(write_valid), 64'(1));
          chk("wr_data", 64'(write_data), 64'(DW'(cur.base + DW'(dbeat))));
          chk("wr_strb", 64'(write_strb), 64'(SW'(cur.base) ^ SW'(dbeat)));
          chk("in_write_ready", 64'(in_write_ready), 64'(P'(write_ready) << e_port));
          chk("wr_quiet", 64'({req_valid, read_ready, in_req_ready, in_read_valid}), 64'(0));
        end
        default: begin
          chk("rd_grant", 64'(grant), 64'(e_port));
          chk("read_ready", 64'(read_ready), 64'(in_read_ready[e_port]));
          chk("in_read_valid", 64'(in_read_valid), 64'(P'(read_valid) << e_port));
          if (read_valid) chk("rd_data", 64'(in_read_data), 64'(DW'(rd_base + DW'(dbeat) + DW'(1))));
          chk("rd_quiet", 64'({req_valid, write_valid, in_req_ready, in_write_ready}), 64'(0));
        end
      endcase
      if (write_valid && write_ready) n_wr_hs++;
      if (|(in_read_valid & in_read_ready)) n_rd_hs++;
    end
    @(posedge clk);
    if (!rst) begin
      case (stage)
        0: if (|in_req_valid) begin e_port = winner(e_ptr, in_req_valid); stage = 1; end
        1: if (req_ready) begin
          cur = q[e_port].pop_front(); dbeat = 0; dtot = eff(cur); rv_hold = 1'b0;
          stage = cur.rw ? 2 : 3;
        end
        default: begin
          if ((stage == 2 && write_ready) || (stage == 3 && read_valid && in_read_ready[e_port])) begin
            dbeat++; rv_hold = 1'b0;
            if (dbeat == dtot) begin stage = 0; e_ptr = (e_port + 1) % P; end
          end else rv_hold = (stage == 3) && read_valid;
        end
      endcase
    end
  endtask

  task automatic drain(input int unsigned bound);
    int unsigned n = 0;
    while ((stage != 0 || !all_empty()) && n < bound) begin step(); n++; end
    vectors++;
    assert (n < bound) else begin
      miscompares++;
      $error("FAIL drain_timeout observed=%0d cycles expected=<%0d", n, bound);
    end
    step();
  endtask

  task automatic clear_inputs();
    in_req_valid = '0; in_req_rw = '0; in_req_burst = '0; in_req_addr = '0; in_req_beats = '0;
    in_write_valid = '0; in_write_data = '0; in_write_strb = '0; in_read_ready = '0;
    req_ready = 1'b0; write_ready = 1'b0; read_valid = 1'b0; read_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < P; p++) q[p].delete();
    stage = 0; e_ptr = 0; e_port = 0; dbeat = 0; dtot = 0; rv_hold = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned n;
    rst = 1'b1; clear_inputs();
    cyc = 0; bp_mode = 0; gen_on = 0; rd_base = '0; n_wr_hs = 0; n_rd_hs = 0;
    #12;
    chk_zero("reset");
    do_reset();

    // Single non-burst write from port 0; beats field must be ignored.
    push(0, 1'b1, 32'h0, 1'b0, 14'd5, 16'h000F);
    drain(50);
    chk("t1_wr_hs", 64'(n_wr_hs), 64'(1));
    // Pointer now at 1: port 1 must win a simultaneous request.
    push(0, 1'b0, 32'h10, 1'b0, 14'd0, 16'h0);
    push(1, 1'b0, 32'h20, 1'b0, 14'd0, 16'h0);
    drain(50);

    do_reset();
    n_wr_hs = 0;
    push(0, 1'b1, 32'h100, 1'b1, 14'd4, 16'h0001);
    push(1, 1'b1, 32'h200, 1'b1, 14'd4, 16'h0011);
    drain(100);
    chk("t2_wr_hs", 64'(n_wr_hs), 64'(8));

    n_rd_hs = 0; rd_base = '0;
    push(1, 1'b0, 32'h300, 1'b1, 14'd4, 16'h0);
    drain(100);
    chk("t3_rd_hs", 64'(n_rd_hs), 64'(4));

    n_wr_hs = 0;
    push(0, 1'b1, 32'h400, 1'b1, 14'd0, 16'h0055);
    drain(50);
    chk("t4_wr_hs", 64'(n_wr_hs), 64'(1));

    // Reset in the middle of a 6-beat write, with the pointer parked away from 0.
    do_reset();
    push(1, 1'b1, 32'h500, 1'b0, 14'd0, 16'h0A00);
    drain(50);
    push(0, 1'b1, 32'h600, 1'b1, 14'd6, 16'h0B00);
    n = 0;
    while (!(stage == 2 && dbeat == 2) && n < 50) begin step(); n++; end
    vectors++;
    assert (n < 50) else begin miscompares++; $error("FAIL t5_reach_beat2 observed=%0d cycles expected=<50", n); end
    #2 rst = 1'b1;
    #1 chk_zero("t5_async_rst");
    do_reset();
    push(2, 1'b0, 32'h700, 1'b0, 14'd0, 16'h0);
    push(1, 1'b0, 32'h800, 1'b0, 14'd0, 16'h0);
    drain(50);

    bp_mode = 1; n_wr_hs = 0; n_rd_hs = 0; rd_base = 16'h0300;
    push(0, 1'b1, 32'h900, 1'b1, 14'd8, 16'h0200);
    push(2, 1'b0, 32'hA00, 1'b1, 14'd8, 16'h0);
    drain(200);
    chk("t6_wr_hs", 64'(n_wr_hs), 64'(8));
    chk("t6_rd_hs", 64'(n_rd_hs), 64'(8));

    bp_mode = 2; rd_base = DW'($urandom); gen_on = 1;
    repeat (3000) step();
    gen_on = 0;
    drain(5000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
